// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: execute-side control, ROM port and presented instruction.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  run;
   logic                  step;
   logic                  exec_done;
   logic                  program_counter_increment;
   logic                  jump_valid;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [15:0]           imem_rdata;
   logic [15:0]           current_instruction;
   logic                  instruction_valid;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  halted;

   // Environment side: drives control and ROM data, observes fetch state.
   modport master (
      output run, step, exec_done, program_counter_increment, jump_valid,
             jump_target, imem_rdata,
      input  imem_addr, current_instruction, instruction_valid, pc, halted
   );

   // Fetch unit side.
   modport slave (
      input  run, step, exec_done, program_counter_increment, jump_valid,
             jump_target, imem_rdata,
      output imem_addr, current_instruction, instruction_valid, pc, halted
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a synchronous ROM and presents one
// stable instruction at a time until the execute side reports completion.
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [15:0]           HALT_WORD  = 16'hFFFF
) (
   input logic                clock,
   input logic                resetn,
   instruction_fetch_if.slave bus
);

   typedef enum logic [1:0] {FETCH, WAIT, READY, HALT} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           instr_q;
   logic                  step_q;
   logic                  step_pending;
   logic                  step_rise;
   logic                  advance;
   logic [ADDR_WIDTH-1:0] pc_next;

   assign step_rise = bus.step & ~step_q;
   // Control inputs only matter while an instruction is being presented.
   assign advance   = (state == READY) & bus.exec_done & (bus.run | step_pending);

   // Next PC: jump beats increment; neither means refetch the same word.
   always_comb begin
      pc_next = pc_q;
      if (bus.jump_valid)
         pc_next = bus.jump_target;
      else if (bus.program_counter_increment)
         pc_next = pc_q + ADDR_WIDTH'(1);
   end

   // Fetch sequencer, PC and step queue.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= FETCH;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         instr_q      <= '0;
         step_q       <= 1'b0;
         step_pending <= 1'b0;
      end else begin
         step_q <= bus.step;
         // One queued step at most; an edge landing on the consuming
         // advance re-arms the queue instead of being lost.
         if (state != HALT) begin
            if (advance)
               step_pending <= step_rise;
            else if (step_rise)
               step_pending <= 1'b1;
         end
         case (state)
            FETCH: state <= WAIT;
            WAIT: begin
               instr_q <= bus.imem_rdata;
               state   <= (bus.imem_rdata == HALT_WORD) ? HALT : READY;
            end
            READY: begin
               if (advance) begin
                  pc_q   <= pc_next;
                  addr_q <= pc_next;
                  state  <= FETCH;
               end
            end
            default: state <= HALT;
         endcase
      end
   end

   assign bus.imem_addr           = addr_q;
   assign bus.pc                  = pc_q;
   assign bus.current_instruction = instr_q;
   assign bus.instruction_valid   = (state == READY);
   assign bus.halted              = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for the main flow,
// then hand-written sequences for wrap/halt and mid-fetch reset.
module tb_instruction_fetch;

   logic clock;
   logic resetn;
   int   tests;
   int   fails;

   logic [15:0] rom [0:65535];

   instruction_fetch_if #(.ADDR_WIDTH(16)) bus ();

   instruction_fetch #(
      .ADDR_WIDTH(16),
      .RESET_PC  (16'h0000),
      .HALT_WORD (16'hFFFF)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous ROM: data for the address sampled at an edge appears after it.
   always @(posedge clock) bus.imem_rdata <= rom[bus.imem_addr];

   typedef struct {
      logic        run, step, exec, inc, jv;
      logic [15:0] jt;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_instr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic run, logic step, logic exec, logic inc,
                               logic jv, logic [15:0] jt, logic v,
                               logic [15:0] p, logic [15:0] ins);
      vec_t e;
      e.run = run; e.step = step; e.exec = exec; e.inc = inc; e.jv = jv;
      e.jt = jt; e.exp_valid = v; e.exp_pc = p; e.exp_instr = ins;
      vecs.push_back(e);
   endfunction

   task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic run, logic step, logic exec, logic inc,
                        logic jv, logic [15:0] jt);
      bus.run = run; bus.step = step; bus.exec_done = exec;
      bus.program_counter_increment = inc; bus.jump_valid = jv;
      bus.jump_target = jt;
   endtask

   task automatic chk_state(string tag, logic v, logic h, logic [15:0] p,
                            logic [15:0] ins);
      chk({tag, " valid"},  {15'd0, bus.instruction_valid}, {15'd0, v});
      chk({tag, " halted"}, {15'd0, bus.halted}, {15'd0, h});
      chk({tag, " pc"},     bus.pc, p);
      chk({tag, " addr"},   bus.imem_addr, p);
      chk({tag, " instr"},  bus.current_instruction, ins);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 65536; i++) rom[i] = 16'(i) ^ 16'hA500;
      rom[0]      = 16'h1234;
      rom[16'hFFFF] = 16'h0BAD;

      // run, step, exec, inc, jv, jt          valid, pc, instr
      add(1,0,0,0,0,16'h0000, 0,16'h0000,16'h0000); // WAIT
      add(1,0,0,0,0,16'h0000, 1,16'h0000,16'h1234); // first valid, 3rd cycle
      add(1,0,0,0,0,16'h0000, 1,16'h0000,16'h1234); // held without exec_done
      add(1,0,1,1,0,16'h0000, 0,16'h0001,16'h1234);
      add(1,0,1,1,0,16'h0000, 0,16'h0001,16'h1234);
      add(1,0,1,1,0,16'h0000, 1,16'h0001,16'hA501);
      add(1,0,1,1,0,16'h0000, 0,16'h0002,16'hA501);
      add(1,0,1,1,0,16'h0000, 0,16'h0002,16'hA501);
      add(1,0,1,1,0,16'h0000, 1,16'h0002,16'hA502);
      add(1,0,1,1,0,16'h0000, 0,16'h0003,16'hA502);
      add(1,0,1,1,0,16'h0000, 0,16'h0003,16'hA502);
      add(1,0,1,1,0,16'h0000, 1,16'h0003,16'hA503);
      add(1,0,1,1,0,16'h0000, 0,16'h0004,16'hA503);
      add(1,0,1,1,0,16'h0000, 0,16'h0004,16'hA503);
      add(1,0,0,0,0,16'h0000, 1,16'h0004,16'hA504);
      add(1,0,1,1,0,16'h0000, 0,16'h0005,16'hA504);
      add(1,0,0,0,0,16'h0000, 0,16'h0005,16'hA504);
      add(1,0,0,0,0,16'h0000, 1,16'h0005,16'hA505);
      add(1,0,1,1,1,16'h0040, 0,16'h0040,16'hA505); // jump beats increment
      add(1,0,0,0,0,16'h0000, 0,16'h0040,16'hA505);
      add(1,0,0,0,0,16'h0000, 1,16'h0040,16'hA540);
      add(1,0,1,0,0,16'h0000, 0,16'h0040,16'hA540); // refetch same address
      add(1,0,0,0,0,16'h0000, 0,16'h0040,16'hA540);
      add(1,0,0,0,0,16'h0000, 1,16'h0040,16'hA540);
      add(0,0,1,1,0,16'h0000, 1,16'h0040,16'hA540); // single-step, no step
      add(0,0,1,1,0,16'h0000, 1,16'h0040,16'hA540);
      add(0,1,1,1,0,16'h0000, 1,16'h0040,16'hA540); // edge queues a step
      add(0,0,1,1,0,16'h0000, 0,16'h0041,16'hA540); // one advance
      add(0,0,1,1,0,16'h0000, 0,16'h0041,16'hA540);
      add(0,0,1,1,0,16'h0000, 1,16'h0041,16'hA541);
      add(0,0,1,1,0,16'h0000, 1,16'h0041,16'hA541); // no second advance
      add(0,0,1,1,0,16'h0000, 1,16'h0041,16'hA541);
      add(0,1,0,0,0,16'h0000, 1,16'h0041,16'hA541);
      add(0,0,1,1,0,16'h0000, 0,16'h0042,16'hA541);
      add(0,1,0,0,0,16'h0000, 0,16'h0042,16'hA541); // edge during FETCH
      add(0,0,0,0,0,16'h0000, 1,16'h0042,16'hA542);
      add(0,1,0,0,0,16'h0000, 1,16'h0042,16'hA542); // second edge dropped
      add(0,0,1,1,0,16'h0000, 0,16'h0043,16'hA542);
      add(0,0,1,1,0,16'h0000, 0,16'h0043,16'hA542);
      add(0,0,1,1,0,16'h0000, 1,16'h0043,16'hA543);
      add(0,0,1,1,0,16'h0000, 1,16'h0043,16'hA543); // only one advance
      add(0,0,1,1,0,16'h0000, 1,16'h0043,16'hA543);
      add(0,1,0,0,0,16'h0000, 1,16'h0043,16'hA543);
      add(0,0,0,0,0,16'h0000, 1,16'h0043,16'hA543);
      add(0,1,1,1,0,16'h0000, 0,16'h0044,16'hA543); // edge on the advance
      add(0,0,1,1,0,16'h0000, 0,16'h0044,16'hA543);
      add(0,0,1,1,0,16'h0000, 1,16'h0044,16'hA544);
      add(0,0,1,1,0,16'h0000, 0,16'h0045,16'hA544); // re-armed step used
      add(0,0,1,1,0,16'h0000, 0,16'h0045,16'hA544);
      add(0,0,1,1,0,16'h0000, 1,16'h0045,16'hA545);
      add(0,0,1,1,0,16'h0000, 1,16'h0045,16'hA545);

      resetn = 1'b0;
      drive(0,0,0,0,0,16'h0000);
      tick();
      tick();
      chk_state("reset", 0, 0, 16'h0000, 16'h0000);

      resetn = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].run, vecs[i].step, vecs[i].exec, vecs[i].inc,
               vecs[i].jv, vecs[i].jt);
         tick();
         chk_state($sformatf("row%0d", i), vecs[i].exp_valid, 0,
                   vecs[i].exp_pc, vecs[i].exp_instr);
      end

      // PC wrap at top of address space, then halt on fetched HALT_WORD.
      drive(1,0,1,0,1,16'hFFFF);
      tick();
      chk("jump ffff pc", bus.pc, 16'hFFFF);
      drive(1,0,0,0,0,16'h0000);
      tick();
      tick();
      chk_state("at ffff", 1, 0, 16'hFFFF, 16'h0BAD);
      rom[0] = 16'hFFFF;
      drive(1,0,1,1,0,16'h0000);
      tick();
      chk("wrap pc", bus.pc, 16'h0000);
      drive(1,0,0,0,0,16'h0000);
      tick();
      tick();
      chk_state("halt", 0, 1, 16'h0000, 16'hFFFF);
      for (int k = 0; k < 6; k++) begin
         drive(k[0], ~k[0], 1, 1, 1, 16'h0020);
         tick();
         chk_state($sformatf("halt hold%0d", k), 0, 1, 16'h0000, 16'hFFFF);
      end

      // Reset pulse while in WAIT with a step queued.
      resetn = 1'b0;
      rom[0] = 16'h1234;
      drive(0,0,0,0,0,16'h0000);
      tick();
      chk_state("halt exit", 0, 0, 16'h0000, 16'h0000);
      resetn = 1'b1;
      tick();
      tick();
      chk_state("rst2 ready", 1, 0, 16'h0000, 16'h1234);
      drive(0,1,1,0,1,16'h0010);
      tick();
      chk_state("rst2 queue", 1, 0, 16'h0000, 16'h1234);
      drive(0,0,1,0,1,16'h0010);
      tick();
      chk_state("rst2 fetch", 0, 0, 16'h0010, 16'h1234);
      drive(0,1,0,0,0,16'h0000);
      tick();
      chk_state("rst2 wait", 0, 0, 16'h0010, 16'h1234);
      resetn = 1'b0;
      tick();
      chk_state("wait reset", 0, 0, 16'h0000, 16'h0000);
      resetn = 1'b1;
      drive(0,0,1,1,0,16'h0000);
      tick();
      chk("post rst valid", {15'd0, bus.instruction_valid}, 16'h0000);
      tick();
      chk_state("post rst ready", 1, 0, 16'h0000, 16'h1234);
      tick();
      tick();
      chk_state("pending cleared", 1, 0, 16'h0000, 16'h1234);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
